branch_redirect_ctrl: RTL and testbench
=======================================

// Module: branch_redirect_ctrl
// PURPOSE
// - Sequences recovery after the branch unit resolves a branch.
// - Front end predicts statically not-taken, so any taken branch is a mispredict.
// - Reports every resolution to the ROB and tracks the oldest pending mispredict.
// - Once that branch commits: flushes the pipeline, then hands the target PC to fetch (valid/ready).
// PARAMETERS
// - ROB_ENTRY_NUM  8  ROB depth; power of two; tags are ROB indices
// - FLUSH_CYCLES   2  cycles flush is held high; must be >= 1
// PORTS
// - clk               in   1                 clock; all state updates on posedge
// - rst               in   1                 reset, asynchronous, active-high
// - br_target         in   `INST_TAG_WIDTH   resolved branch tag; `TAG_INVALID = none this cycle
// - br_taken          in   1                 branch compare result
// - br_next_pc        in   `COMMON_WIDTH     taken target (pc + offset)
// - rob_head          in   `INST_TAG_WIDTH   tag of oldest in-flight ROB entry
// - rob_commit_valid  in   1                 an entry commits this cycle
// - rob_commit_tag    in   `INST_TAG_WIDTH   tag of the committing entry
// - brc_done_valid    out  1                 branch completion report to ROB
// - brc_done_tag      out  `INST_TAG_WIDTH   tag being reported
// - flush             out  1                 squash all in-flight work
// - stall_issue       out  1                 hold dispatch
// - redirect_valid    out  1                 redirect request to fetch
// - redirect_pc       out  `COMMON_WIDTH     redirect target
// - redirect_ready    in   1                 fetch accepts redirect
// BEHAVIOUR
// - Reset (async): state=IDLE; brc_done_tag=`TAG_INVALID; all other outputs and registers 0.
//   - Asserting rst mid-FLUSH/REDIRECT abandons recovery immediately.
// - Inputs are sampled at posedge. The branch unit drives on negedge, so inputs are stable by then.
// - Resolution is valid iff br_target !== `TAG_INVALID.
// - Done report:
//   - Registered, 1-cycle latency, in IDLE and HOLD.
//   - Every valid resolution gives brc_done_valid=1 with brc_done_tag=br_target.
//   - Otherwise brc_done_valid=0 and brc_done_tag=`TAG_INVALID.
//   - In FLUSH/REDIRECT resolutions are ignored: no report, no capture (they belong to squashed work).
// - Age: age(t) = (t - rob_head) mod ROB_ENTRY_NUM; smaller age = older. Tags are unique.
// - FSM transitions:
//   - IDLE: valid resolution with br_taken=1 captures pend_tag and pend_pc -> HOLD.
//   - HOLD:
//     - A taken resolution with age < age(pend_tag) replaces pend_tag and pend_pc; a younger one is dropped.
//     - rob_commit_valid && rob_commit_tag==pend_tag -> FLUSH; cnt=FLUSH_CYCLES-1.
//     - Commit has priority over a same-cycle replacement.
//   - FLUSH: flush=1 and stall_issue=1; cnt decrements; at cnt==0 -> REDIRECT.
//   - REDIRECT:
//     - redirect_valid=1, redirect_pc=pend_pc, stall_issue=1.
//     - pc is held stable until redirect_ready.
//     - The cycle with valid&&ready completes the handshake -> IDLE; redirect_valid=0 the next cycle.
// - flush, stall_issue and redirect_valid are registered outputs decoded from the next state.
//   - flush rises the cycle after the commit edge.
//   - The total flush pulse width equals FLUSH_CYCLES.
// - The same branch's done report and capture happen in the same cycle; the commit comes later from the ROB.
// STRUCTURE
// - Shared package brc_pkg:
//   - enum brc_state_e {BRC_IDLE, BRC_HOLD, BRC_FLUSH, BRC_REDIRECT}
//   - function rob_age(tag, head)
//   - `TAG_INVALID and widths come from common_def.h
// - Sub-module brc_age_cmp: combinational "a older than b given head" comparator; instantiated once.
// TESTING (ROB_ENTRY_NUM=8, FLUSH_CYCLES=2)
// - Not-taken tag 3 -> next cycle brc_done_valid=1, tag 3; flush/redirect_valid stay 0.
// - Taken tag 5, pc 0x100; commit tag 5 four cycles later:
//   - flush=1 for exactly 2 cycles, then redirect_valid=1, pc 0x100.
//   - ready=0 for 3 cycles -> pc stable; ready=1 -> IDLE, stall_issue=0.
// - head 2; taken tag 6 pc 0x200 then taken tag 4 pc 0x300 -> pending tag 4; commit 4 -> redirect 0x300.
//   - Reverse order -> tag 6 dropped, still 0x300.
// - Wrap-around: head 6, pending tag 1 (age 3); taken tag 7 (age 1) -> replaces; commit 7 -> redirect its pc.
// - Taken tag 2 arriving during FLUSH -> no brc_done_valid, no new capture after return to IDLE.
// - Assert rst during REDIRECT -> all outputs 0 asynchronously; after release, taken tag 1 recovers normally.

Source files
------------

// File: rtl/brc_pkg.sv
// Shared types, widths and ROB age helper for the branch redirect controller.
package brc_pkg;

    localparam int INST_TAG_WIDTH = 4;
    localparam int COMMON_WIDTH   = 32;
    // Outside the ROB index range, so it can never collide with a real entry.
    localparam logic [INST_TAG_WIDTH-1:0] TAG_INVALID = '1;

    typedef enum logic [1:0] {
        BRC_IDLE,
        BRC_HOLD,
        BRC_FLUSH,
        BRC_REDIRECT
    } brc_state_e;

    // Raw distance from head; the caller masks it down to the ROB index width.
    function automatic logic [INST_TAG_WIDTH-1:0] rob_age(
        input logic [INST_TAG_WIDTH-1:0] tag,
        input logic [INST_TAG_WIDTH-1:0] head
    );
        return tag - head;
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// Branch-resolution, ROB and fetch-redirect signals of the redirect controller.
interface branch_redirect_ctrl_if;
    import brc_pkg::*;

    logic [INST_TAG_WIDTH-1:0] br_target;
    logic                      br_taken;
    logic [COMMON_WIDTH-1:0]   br_next_pc;
    logic [INST_TAG_WIDTH-1:0] rob_head;
    logic                      rob_commit_valid;
    logic [INST_TAG_WIDTH-1:0] rob_commit_tag;
    logic                      brc_done_valid;
    logic [INST_TAG_WIDTH-1:0] brc_done_tag;
    logic                      flush;
    logic                      stall_issue;
    logic                      redirect_valid;
    logic [COMMON_WIDTH-1:0]   redirect_pc;
    logic                      redirect_ready;

    modport master (
        output br_target, br_taken, br_next_pc, rob_head,
               rob_commit_valid, rob_commit_tag, redirect_ready,
        input  brc_done_valid, brc_done_tag, flush, stall_issue,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  br_target, br_taken, br_next_pc, rob_head,
               rob_commit_valid, rob_commit_tag, redirect_ready,
        output brc_done_valid, brc_done_tag, flush, stall_issue,
               redirect_valid, redirect_pc
    );

endinterface

// File: rtl/brc_age_cmp.sv
// Combinational comparator: is tag a older than tag b relative to the ROB head.
module brc_age_cmp
    import brc_pkg::*;
#(
    parameter int ROB_ENTRY_NUM = 8
) (
    input  logic [INST_TAG_WIDTH-1:0] i_tag_a,
    input  logic [INST_TAG_WIDTH-1:0] i_tag_b,
    input  logic [INST_TAG_WIDTH-1:0] i_head,
    output logic                      o_a_older
);

    localparam logic [INST_TAG_WIDTH-1:0] AGE_MASK = INST_TAG_WIDTH'(ROB_ENTRY_NUM - 1);

    logic [INST_TAG_WIDTH-1:0] w_age_a;
    logic [INST_TAG_WIDTH-1:0] w_age_b;

    assign w_age_a   = rob_age(i_tag_a, i_head) & AGE_MASK;
    assign w_age_b   = rob_age(i_tag_b, i_head) & AGE_MASK;
    assign o_a_older = (w_age_a < w_age_b);

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Tracks the oldest taken (mispredicted) branch; on its commit flushes, then redirects fetch.
module branch_redirect_ctrl
    import brc_pkg::*;
#(
    parameter int ROB_ENTRY_NUM = 8,
    parameter int FLUSH_CYCLES  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    branch_redirect_ctrl_if.slave  io_brc
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    brc_state_e                r_state;
    logic [INST_TAG_WIDTH-1:0] r_pend_tag;
    logic [COMMON_WIDTH-1:0]   r_pend_pc;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_done_valid;
    logic [INST_TAG_WIDTH-1:0] r_done_tag;
    logic                      r_flush;
    logic                      r_stall;
    logic                      r_redir_valid;
    logic [COMMON_WIDTH-1:0]   r_redir_pc;

    logic w_res_valid;
    logic w_taken_res;
    logic w_commit_hit;
    logic w_new_older;
    logic w_accept_res;

    assign w_res_valid  = (io_brc.br_target != TAG_INVALID);
    assign w_taken_res  = w_res_valid && io_brc.br_taken;
    assign w_commit_hit = io_brc.rob_commit_valid && (io_brc.rob_commit_tag == r_pend_tag);
    // Resolutions seen during recovery belong to squashed work.
    assign w_accept_res = (r_state == BRC_IDLE) || (r_state == BRC_HOLD);

    brc_age_cmp #(
        .ROB_ENTRY_NUM (ROB_ENTRY_NUM)
    ) u_age_cmp (
        .i_tag_a   (io_brc.br_target),
        .i_tag_b   (r_pend_tag),
        .i_head    (io_brc.rob_head),
        .o_a_older (w_new_older)
    );

    // Outputs are registered alongside the state they decode from.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= BRC_IDLE;
            r_pend_tag    <= '0;
            r_pend_pc     <= '0;
            r_cnt         <= '0;
            r_done_valid  <= 1'b0;
            r_done_tag    <= TAG_INVALID;
            r_flush       <= 1'b0;
            r_stall       <= 1'b0;
            r_redir_valid <= 1'b0;
            r_redir_pc    <= '0;
        end else begin
            r_done_valid <= w_accept_res && w_res_valid;
            r_done_tag   <= (w_accept_res && w_res_valid) ? io_brc.br_target : TAG_INVALID;

            case (r_state)
                BRC_IDLE: begin
                    if (w_taken_res) begin
                        r_pend_tag <= io_brc.br_target;
                        r_pend_pc  <= io_brc.br_next_pc;
                        r_state    <= BRC_HOLD;
                    end
                end
                BRC_HOLD: begin
                    if (w_commit_hit) begin
                        r_state <= BRC_FLUSH;
                        r_cnt   <= CNT_LOAD;
                        r_flush <= 1'b1;
                        r_stall <= 1'b1;
                    end else if (w_taken_res && w_new_older) begin
                        r_pend_tag <= io_brc.br_target;
                        r_pend_pc  <= io_brc.br_next_pc;
                    end
                end
                BRC_FLUSH: begin
                    if (r_cnt == '0) begin
                        r_state       <= BRC_REDIRECT;
                        r_flush       <= 1'b0;
                        r_redir_valid <= 1'b1;
                        r_redir_pc    <= r_pend_pc;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                BRC_REDIRECT: begin
                    if (io_brc.redirect_ready) begin
                        r_state       <= BRC_IDLE;
                        r_stall       <= 1'b0;
                        r_redir_valid <= 1'b0;
                    end
                end
                default: r_state <= BRC_IDLE;
            endcase
        end
    end

    assign io_brc.brc_done_valid = r_done_valid;
    assign io_brc.brc_done_tag   = r_done_tag;
    assign io_brc.flush          = r_flush;
    assign io_brc.stall_issue    = r_stall;
    assign io_brc.redirect_valid = r_redir_valid;
    assign io_brc.redirect_pc    = r_redir_pc;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed vector bench for branch_redirect_ctrl (ROB_ENTRY_NUM=8, FLUSH_CYCLES=2).
module tb_branch_redirect_ctrl;
    import brc_pkg::*;

    typedef struct {
        logic [3:0]  tag;
        logic        taken;
        logic [31:0] pc;
        logic [3:0]  head;
        logic        cv;
        logic [3:0]  ct;
        logic        rdy;
        logic        e_dv;
        logic [3:0]  e_dt;
        logic        e_flush;
        logic        e_stall;
        logic        e_rv;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NV = 39;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    vec_t vecs [NV];

    branch_redirect_ctrl_if bus ();

    branch_redirect_ctrl #(
        .ROB_ENTRY_NUM (8),
        .FLUSH_CYCLES  (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_brc (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(int tag, int tk, int pc, int head, int cv, int ct, int rdy,
                                int dv, int dt, int f, int s, int rv, int epc);
        vec_t v;
        v.tag = 4'(tag);   v.taken = 1'(tk);  v.pc = 32'(pc);  v.head = 4'(head);
        v.cv = 1'(cv);     v.ct = 4'(ct);     v.rdy = 1'(rdy);
        v.e_dv = 1'(dv);   v.e_dt = 4'(dt);   v.e_flush = 1'(f);
        v.e_stall = 1'(s); v.e_rv = 1'(rv);   v.e_pc = 32'(epc);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] tag, input logic tk, input logic [31:0] pc,
                         input logic [3:0] head, input logic cv, input logic [3:0] ct,
                         input logic rdy);
        bus.br_target        = tag;
        bus.br_taken         = tk;
        bus.br_next_pc       = pc;
        bus.rob_head         = head;
        bus.rob_commit_valid = cv;
        bus.rob_commit_tag   = ct;
        bus.redirect_ready   = rdy;
    endtask

    task automatic step(input logic [3:0] tag, input logic tk, input logic [31:0] pc,
                        input logic cv, input logic [3:0] ct, input logic rdy);
        @(negedge clk);
        drive(tag, tk, pc, 4'd0, cv, ct, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tagname);
        chk({tagname, "_done_valid"}, 32'(bus.brc_done_valid), 32'd0);
        chk({tagname, "_done_tag"},   32'(bus.brc_done_tag),   32'hF);
        chk({tagname, "_flush"},      32'(bus.flush),          32'd0);
        chk({tagname, "_stall"},      32'(bus.stall_issue),    32'd0);
        chk({tagname, "_rv"},         32'(bus.redirect_valid), 32'd0);
        chk({tagname, "_rpc"},        bus.redirect_pc,         32'd0);
    endtask

    initial begin
        int flush_cnt;
        bit seen;
        n_checks = 0;
        n_errors = 0;

        // {tag, taken, pc, head, commit_v, commit_tag, ready} -> {done_v, done_tag, flush, stall, rv, pc}
        vecs[0]  = mk(3, 0, 0,     0, 0, 0, 0,  1, 3,  0, 0, 0, 0);
        vecs[1]  = mk(15,0, 0,     0, 0, 0, 0,  0, 15, 0, 0, 0, 0);
        vecs[2]  = mk(5, 1, 'h100, 0, 0, 0, 0,  1, 5,  0, 0, 0, 0);
        vecs[3]  = mk(15,0, 0,     0, 0, 0, 0,  0, 15, 0, 0, 0, 0);
        vecs[4]  = mk(15,0, 0,     0, 0, 0, 0,  0, 15, 0, 0, 0, 0);
        vecs[5]  = mk(15,0, 0,     0, 0, 0, 0,  0, 15, 0, 0, 0, 0);
        vecs[6]  = mk(15,0, 0,     0, 1, 5, 0,  0, 15, 1, 1, 0, 0);
        vecs[7]  = mk(15,0, 0,     0, 0, 0, 0,  0, 15, 1, 1, 0, 0);
        vecs[8]  = mk(15,0, 0,     0, 0, 0, 0,  0, 15, 0, 1, 1, 'h100);
        vecs[9]  = mk(15,0, 0,     0, 0, 0, 0,  0, 15, 0, 1, 1, 'h100);
        vecs[10] = mk(15,0, 0,     0, 0, 0, 0,  0, 15, 0, 1, 1, 'h100);
        vecs[11] = mk(15,0, 0,     0, 0, 0, 0,  0, 15, 0, 1, 1, 'h100);
        vecs[12] = mk(15,0, 0,     0, 0, 0, 1,  0, 15, 0, 0, 0, 0);
        vecs[13] = mk(6, 1, 'h200, 2, 0, 0, 0,  1, 6,  0, 0, 0, 0);
        vecs[14] = mk(4, 1, 'h300, 2, 0, 0, 0,  1, 4,  0, 0, 0, 0);
        vecs[15] = mk(15,0, 0,     2, 1, 4, 0,  0, 15, 1, 1, 0, 0);
        vecs[16] = mk(15,0, 0,     2, 0, 0, 0,  0, 15, 1, 1, 0, 0);
        vecs[17] = mk(15,0, 0,     2, 0, 0, 1,  0, 15, 0, 1, 1, 'h300);
        vecs[18] = mk(15,0, 0,     2, 0, 0, 1,  0, 15, 0, 0, 0, 0);
        vecs[19] = mk(4, 1, 'h300, 2, 0, 0, 0,  1, 4,  0, 0, 0, 0);
        vecs[20] = mk(6, 1, 'h200, 2, 0, 0, 0,  1, 6,  0, 0, 0, 0);
        vecs[21] = mk(15,0, 0,     2, 1, 6, 0,  0, 15, 0, 0, 0, 0);
        vecs[22] = mk(15,0, 0,     2, 1, 4, 0,  0, 15, 1, 1, 0, 0);
        vecs[23] = mk(15,0, 0,     2, 0, 0, 0,  0, 15, 1, 1, 0, 0);
        vecs[24] = mk(15,0, 0,     2, 0, 0, 0,  0, 15, 0, 1, 1, 'h300);
        vecs[25] = mk(15,0, 0,     2, 0, 0, 1,  0, 15, 0, 0, 0, 0);
        vecs[26] = mk(1, 1, 'h400, 6, 0, 0, 0,  1, 1,  0, 0, 0, 0);
        vecs[27] = mk(7, 1, 'h500, 6, 0, 0, 0,  1, 7,  0, 0, 0, 0);
        vecs[28] = mk(15,0, 0,     6, 1, 7, 0,  0, 15, 1, 1, 0, 0);
        vecs[29] = mk(15,0, 0,     6, 0, 0, 0,  0, 15, 1, 1, 0, 0);
        vecs[30] = mk(15,0, 0,     6, 0, 0, 0,  0, 15, 0, 1, 1, 'h500);
        vecs[31] = mk(15,0, 0,     6, 0, 0, 1,  0, 15, 0, 0, 0, 0);
        vecs[32] = mk(5, 1, 'h600, 0, 0, 0, 0,  1, 5,  0, 0, 0, 0);
        vecs[33] = mk(2, 1, 'h700, 0, 1, 5, 0,  1, 2,  1, 1, 0, 0);
        vecs[34] = mk(2, 1, 'h800, 0, 0, 0, 0,  0, 15, 1, 1, 0, 0);
        vecs[35] = mk(2, 1, 'h800, 0, 0, 0, 0,  0, 15, 0, 1, 1, 'h600);
        vecs[36] = mk(2, 1, 'h800, 0, 0, 0, 1,  0, 15, 0, 0, 0, 0);
        vecs[37] = mk(15,0, 0,     0, 0, 0, 0,  0, 15, 0, 0, 0, 0);
        vecs[38] = mk(15,0, 0,     0, 1, 2, 0,  0, 15, 0, 0, 0, 0);

        rst = 1'b1;
        drive(4'hF, 1'b0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].tag, vecs[i].taken, vecs[i].pc, vecs[i].head,
                  vecs[i].cv, vecs[i].ct, vecs[i].rdy);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_valid", i), 32'(bus.brc_done_valid), 32'(vecs[i].e_dv));
            chk($sformatf("v%0d_done_tag", i),   32'(bus.brc_done_tag),   32'(vecs[i].e_dt));
            chk($sformatf("v%0d_flush", i),      32'(bus.flush),          32'(vecs[i].e_flush));
            chk($sformatf("v%0d_stall", i),      32'(bus.stall_issue),    32'(vecs[i].e_stall));
            chk($sformatf("v%0d_rv", i),         32'(bus.redirect_valid), 32'(vecs[i].e_rv));
            if (vecs[i].e_rv)
                chk($sformatf("v%0d_rpc", i), bus.redirect_pc, vecs[i].e_pc);
        end

        // Reach REDIRECT, then pull reset between clock edges.
        step(4'd3, 1'b1, 32'h900, 1'b0, 4'd0, 1'b0);
        step(4'hF, 1'b0, 32'd0,   1'b1, 4'd3, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            step(4'hF, 1'b0, 32'd0, 1'b0, 4'd0, 1'b0);
            seen = bus.redirect_valid;
        end
        chk("arst_reach_redirect", 32'(seen), 32'd1);
        chk("arst_pre_pc", bus.redirect_pc, 32'h900);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_idle_outputs("arst");
        @(negedge clk);
        rst = 1'b0;

        // Normal recovery after reset, measuring the flush pulse width.
        step(4'd1, 1'b1, 32'hA00, 1'b0, 4'd0, 1'b0);
        chk("post_rst_done_tag", 32'(bus.brc_done_tag), 32'd1);
        step(4'hF, 1'b0, 32'd0, 1'b1, 4'd1, 1'b0);
        flush_cnt = 0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (bus.flush) flush_cnt++;
            seen = bus.redirect_valid;
            if (!seen) step(4'hF, 1'b0, 32'd0, 1'b0, 4'd0, 1'b0);
        end
        chk("post_rst_redirect_seen", 32'(seen), 32'd1);
        chk("post_rst_flush_width", 32'(flush_cnt), 32'd2);
        chk("post_rst_pc", bus.redirect_pc, 32'hA00);
        step(4'hF, 1'b0, 32'd0, 1'b0, 4'd0, 1'b1);
        chk("post_rst_rv_drop", 32'(bus.redirect_valid), 32'd0);
        chk("post_rst_stall_drop", 32'(bus.stall_issue), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
